lbm_step_scheduler: RTL

- Top-level sequencer for the lattice-Boltzmann datapath: sweeps cell addresses into the collide/stream pipeline, drains it, then swaps the ping-pong distribution banks.
- After a programmable number of timesteps it pulses frame_ready to the BRAM readout/AXI-stream controller and waits for the frame to leave before computing resumes.
- Sits between the host control registers and the solver pipeline plus the 9-direction BRAM readout path.

---
 rtl/lbm_step_scheduler.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/lbm_step_scheduler.sv
// Top-level sequencer for the lattice-Boltzmann datapath: sweeps cells into the
// collide/stream pipeline, drains it, swaps ping-pong banks and hands frames to readout.
module lbm_step_scheduler #(
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12,
  parameter int PIPE_LATENCY  = 6,
  parameter int STEP_WIDTH    = 8,
  parameter int FRAME_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic [STEP_WIDTH-1:0]    steps_per_frame,
  input  logic                     cell_ready,
  output logic                     cell_valid,
  output logic [ADDRESS_WIDTH-1:0] cell_addr,
  output logic                     bank_sel,
  output logic                     frame_ready,
  input  logic                     readout_done,
  output logic                     busy,
  output logic [STEP_WIDTH-1:0]    step_count,
  output logic [FRAME_WIDTH-1:0]   frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_SWAP,
    S_READOUT
  } state_t;

  localparam int DRAIN_WIDTH = $clog2(PIPE_LATENCY + 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR  = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [DRAIN_WIDTH-1:0]   DRAIN_LOAD = DRAIN_WIDTH'(PIPE_LATENCY);

  state_t                   state_q, state_d;
  logic                     cell_valid_d;
  logic [ADDRESS_WIDTH-1:0] cell_addr_d;
  logic                     bank_sel_d;
  logic                     frame_ready_d;
  logic                     busy_d;
  logic [STEP_WIDTH-1:0]    step_count_d;
  logic [STEP_WIDTH-1:0]    step_inc;
  logic [FRAME_WIDTH-1:0]   frame_count_d;
  logic                     stop_q, stop_d;
  logic [STEP_WIDTH-1:0]    steps_q, steps_d;
  logic [DRAIN_WIDTH-1:0]   drain_q, drain_d;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    cell_valid_d  = cell_valid;
    cell_addr_d   = cell_addr;
    bank_sel_d    = bank_sel;
    frame_ready_d = 1'b0;
    step_count_d  = step_count;
    frame_count_d = frame_count;
    stop_d        = stop_q;
    steps_d       = steps_q;
    drain_d       = drain_q;
    step_inc      = step_count + STEP_WIDTH'(1);

    // A stop pulse is remembered until the next frame boundary; it means nothing in IDLE.
    if (state_q != S_IDLE && stop) stop_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          steps_d      = (steps_per_frame == '0) ? STEP_WIDTH'(1) : steps_per_frame;
          step_count_d = '0;
          cell_valid_d = 1'b1;
          cell_addr_d  = '0;
          state_d      = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (cell_valid && cell_ready) begin
          if (cell_addr == LAST_ADDR) begin
            cell_valid_d = 1'b0;
            cell_addr_d  = '0;
            drain_d      = DRAIN_LOAD;
            state_d      = S_DRAIN;
          end else begin
            cell_addr_d = cell_addr + ADDRESS_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - DRAIN_WIDTH'(1);
        if (drain_q <= DRAIN_WIDTH'(1)) state_d = S_SWAP;
      end
      S_SWAP: begin
        bank_sel_d = ~bank_sel;
        if (step_inc == steps_q) begin
          step_count_d  = '0;
          frame_ready_d = 1'b1;
          state_d       = S_READOUT;
        end else begin
          step_count_d = step_inc;
          cell_valid_d = 1'b1;
          state_d      = S_SWEEP;
        end
      end
      S_READOUT: begin
        if (readout_done) begin
          frame_count_d = frame_count + FRAME_WIDTH'(1);
          // A stop arriving with the last readout beat still ends this frame.
          if (stop_q || stop) begin
            stop_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cell_valid_d = 1'b1;
            state_d      = S_SWEEP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cell_valid  <= 1'b0;
      cell_addr   <= '0;
      bank_sel    <= 1'b0;
      frame_ready <= 1'b0;
      busy        <= 1'b0;
      step_count  <= '0;
      frame_count <= '0;
      stop_q      <= 1'b0;
      steps_q     <= STEP_WIDTH'(1);
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      cell_valid  <= cell_valid_d;
      cell_addr   <= cell_addr_d;
      bank_sel    <= bank_sel_d;
      frame_ready <= frame_ready_d;
      busy        <= busy_d;
      step_count  <= step_count_d;
      frame_count <= frame_count_d;
      stop_q      <= stop_d;
      steps_q     <= steps_d;
      drain_q     <= drain_d;
    end
  end

endmodule
